// File: rtl/dsp48a1_slice.sv
// dsp48a1_slice: 18x18 multiply-accumulate slice in the style of the Spartan-6 DSP48A1.
// Datapath: B source select -> B0 -> pre-adder (D +/- B0) -> B1; A -> A0 -> A1;
// M = B1 * A1 (unsigned) -> M stage; post-adder Z +/- (X + CIN) -> P / CARRYOUT stages.
// Ports:
//   CLK                      clock, rising edge
//   RST{A,B,C,D,M,P,OPMODE,CARRYIN}  async active-low resets, one per register group
//   CE{A,B,C,D,M,P,OPMODE,CARRYIN}   active-high clock enables, one per register group
//   A, B, BCIN, D  [17:0]    multiplier / pre-adder operands (BCIN = cascaded B)
//   C, PCIN        [47:0]    post-adder operand / cascaded P
//   CARRYIN                  external carry-in
//   OPMODE         [7:0]     operation select
//   M [35:0], P/PCOUT [47:0], BCOUT [17:0], CARRYOUT/CARRYOUTF  results
module dsp48a1_slice #(
  parameter int unsigned A0REG       = 0,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 0,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter string       CARRYINSEL  = "OPMODE5",
  parameter string       B_INPUT     = "DIRECT"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTOPMODE,
  input  logic        RSTCARRYIN,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CEOPMODE,
  input  logic        CECARRYIN,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic [17:0] BCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);
  localparam int unsigned OPW = 18;
  localparam int unsigned MW  = 36;
  localparam int unsigned PW  = 48;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned OMW = 8;

  localparam bit B_DIRECT     = (B_INPUT == "DIRECT");
  localparam bit B_CASCADE    = (B_INPUT == "CASCADE");
  localparam bit CIN_FROM_OP5 = (CARRYINSEL == "OPMODE5");
  localparam bit CIN_FROM_PIN = (CARRYINSEL == "CARRYIN");

  logic [OPW-1:0] a0_q, a1_q, b0_d, b0_q, b1_d, b1_q, d_q;
  logic [PW-1:0]  c_q, p_d, p_q, x_mux, z_mux;
  logic [MW-1:0]  m_d, m_q;
  logic [OMW-1:0] opmode_q;
  logic           cin_d, cin_q, co_d, co_q;
  logic [SW-1:0]  post_sum;

  // OPMODE stage
  if (OPMODEREG != 0) begin : g_op_reg
    always_ff @(posedge CLK or negedge RSTOPMODE)
      if (!RSTOPMODE)    opmode_q <= '0;
      else if (CEOPMODE) opmode_q <= OPMODE;
  end else begin : g_op_wire
    assign opmode_q = OPMODE;
  end

  // A0 / A1 stages
  if (A0REG != 0) begin : g_a0_reg
    always_ff @(posedge CLK or negedge RSTA)
      if (!RSTA)    a0_q <= '0;
      else if (CEA) a0_q <= A;
  end else begin : g_a0_wire
    assign a0_q = A;
  end

  if (A1REG != 0) begin : g_a1_reg
    always_ff @(posedge CLK or negedge RSTA)
      if (!RSTA)    a1_q <= '0;
      else if (CEA) a1_q <= a0_q;
  end else begin : g_a1_wire
    assign a1_q = a0_q;
  end

  // B source select and B0 stage
  assign b0_d = B_DIRECT ? B : (B_CASCADE ? BCIN : '0);

  if (B0REG != 0) begin : g_b0_reg
    always_ff @(posedge CLK or negedge RSTB)
      if (!RSTB)    b0_q <= '0;
      else if (CEB) b0_q <= b0_d;
  end else begin : g_b0_wire
    assign b0_q = b0_d;
  end

  // D stage
  if (DREG != 0) begin : g_d_reg
    always_ff @(posedge CLK or negedge RSTD)
      if (!RSTD)    d_q <= '0;
      else if (CED) d_q <= D;
  end else begin : g_d_wire
    assign d_q = D;
  end

  // Pre-adder: D +/- B0 when enabled, wraps at 18 bits
  always_comb begin
    b1_d = b0_q;
    if (opmode_q[4]) b1_d = opmode_q[6] ? (d_q - b0_q) : (d_q + b0_q);
  end

  if (B1REG != 0) begin : g_b1_reg
    always_ff @(posedge CLK or negedge RSTB)
      if (!RSTB)    b1_q <= '0;
      else if (CEB) b1_q <= b1_d;
  end else begin : g_b1_wire
    assign b1_q = b1_d;
  end

  // C stage
  if (CREG != 0) begin : g_c_reg
    always_ff @(posedge CLK or negedge RSTC)
      if (!RSTC)    c_q <= '0;
      else if (CEC) c_q <= C;
  end else begin : g_c_wire
    assign c_q = C;
  end

  // Unsigned multiplier and M stage
  assign m_d = MW'(b1_q) * MW'(a1_q);

  if (MREG != 0) begin : g_m_reg
    always_ff @(posedge CLK or negedge RSTM)
      if (!RSTM)    m_q <= '0;
      else if (CEM) m_q <= m_d;
  end else begin : g_m_wire
    assign m_q = m_d;
  end

  // Carry-in select and stage
  assign cin_d = CIN_FROM_OP5 ? opmode_q[5] : (CIN_FROM_PIN ? CARRYIN : 1'b0);

  if (CARRYINREG != 0) begin : g_cin_reg
    always_ff @(posedge CLK or negedge RSTCARRYIN)
      if (!RSTCARRYIN)    cin_q <= 1'b0;
      else if (CECARRYIN) cin_q <= cin_d;
  end else begin : g_cin_wire
    assign cin_q = cin_d;
  end

  // X / Z operand muxes
  always_comb begin
    x_mux = '0;
    unique case (opmode_q[1:0])
      2'b00: x_mux = '0;
      2'b01: x_mux = PW'(m_q);
      2'b10: x_mux = p_q;
      2'b11: x_mux = {d_q[11:0], a1_q, b1_q};
    endcase
  end

  always_comb begin
    z_mux = '0;
    unique case (opmode_q[3:2])
      2'b00: z_mux = '0;
      2'b01: z_mux = PCIN;
      2'b10: z_mux = p_q;
      2'b11: z_mux = c_q;
    endcase
  end

  // Post-adder at 49 bits; bit 48 is carry (add) or borrow (subtract)
  always_comb begin
    if (opmode_q[7]) post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + SW'(cin_q));
    else             post_sum = {1'b0, z_mux} + {1'b0, x_mux} + SW'(cin_q);
  end

  assign p_d  = post_sum[PW-1:0];
  assign co_d = post_sum[PW];

  if (PREG != 0) begin : g_p_reg
    always_ff @(posedge CLK or negedge RSTP)
      if (!RSTP)    p_q <= '0;
      else if (CEP) p_q <= p_d;
  end else begin : g_p_wire
    assign p_q = p_d;
  end

  // Carry-out shares the carry-in reset / enable group
  if (CARRYOUTREG != 0) begin : g_co_reg
    always_ff @(posedge CLK or negedge RSTCARRYIN)
      if (!RSTCARRYIN)    co_q <= 1'b0;
      else if (CECARRYIN) co_q <= co_d;
  end else begin : g_co_wire
    assign co_q = co_d;
  end

  assign M         = m_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign BCOUT     = b1_q;
  assign CARRYOUT  = co_q;
  assign CARRYOUTF = co_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Self-checking bench for dsp48a1_slice with default parameters: directed
// scenarios followed by random steady-state operations against an arithmetic model.
module tb_dsp48a1_slice;
  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN;
  logic [17:0] A, B, BCIN, D;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic [17:0] BCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int errors = 0;
  int checks = 0;

  // Reference-model scratch values
  logic [17:0] r_b1;
  logic [35:0] r_m;
  logic [47:0] r_x, r_z;
  logic [48:0] r_sum;
  logic [47:0] exp_p;
  logic [1:0]  xs, zs;

  dsp48a1_slice dut (
    .CLK(CLK),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD),
    .RSTM(RSTM), .RSTP(RSTP), .RSTOPMODE(RSTOPMODE), .RSTCARRYIN(RSTCARRYIN),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED),
    .CEM(CEM), .CEP(CEP), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
    .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .M(M), .P(P), .PCOUT(PCOUT), .BCOUT(BCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_resets(input logic v);
    RSTA = v; RSTB = v; RSTC = v; RSTD = v;
    RSTM = v; RSTP = v; RSTOPMODE = v; RSTCARRYIN = v;
  endtask

  // Steady-state result of one operation, computed from the datapath rules
  task automatic model(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                       input logic [47:0] c, input logic [47:0] pcin, input logic [7:0] op);
    if (op[4]) r_b1 = op[6] ? 18'(d - b) : 18'(d + b);
    else       r_b1 = b;
    r_m = 36'(r_b1) * 36'(a);
    case (op[1:0])
      2'b00:   r_x = 48'd0;
      2'b01:   r_x = 48'(r_m);
      default: r_x = {d[11:0], a, r_b1};
    endcase
    case (op[3:2])
      2'b00:   r_z = 48'd0;
      2'b01:   r_z = pcin;
      default: r_z = c;
    endcase
    if (op[7]) r_sum = 49'(r_z) - (49'(r_x) + 49'(op[5]));
    else       r_sum = 49'(r_z) + 49'(r_x) + 49'(op[5]);
  endtask

  initial begin
    set_resets(1'b0);
    CEA = 1; CEB = 1; CEC = 1; CED = 1; CEM = 1; CEP = 1; CEOPMODE = 1; CECARRYIN = 1;
    A = 18'd5; B = 18'd76; BCIN = 18'd0; D = 18'd33; C = 48'd21; PCIN = 48'd0;
    CARRYIN = 1'b0; OPMODE = 8'b00011101;

    // Reset held while inputs toggle the clock
    clk_n(4);
    check("rst_p", 64'(P), 64'd0);
    check("rst_m", 64'(M), 64'd0);
    check("rst_co", 64'(CARRYOUT), 64'd0);
    check("rst_bcout", 64'(BCOUT), 64'd0);

    // Release: pipeline refills
    set_resets(1'b1);
    clk_n(5);
    check("resume_m", 64'(M), 64'd545);
    check("resume_p", 64'(P), 64'd566);

    // Pre-add, multiply, plus C; port carry-in ignored
    CARRYIN = 1'b1;
    clk_n(5);
    check("preadd_m", 64'(M), 64'd545);
    check("preadd_p", 64'(P), 64'd566);
    check("preadd_co", 64'(CARRYOUT), 64'd0);
    check("pcout_eq_p", 64'(PCOUT), 64'd566);

    // Pre-subtract
    CARRYIN = 1'b0; D = 18'd86; OPMODE = 8'b01010001;
    clk_n(5);
    check("presub_m", 64'(M), 64'd50);
    check("presub_p", 64'(P), 64'd50);
    check("presub_co", 64'(CARRYOUT), 64'd0);

    // Post-subtract: C - M
    C = 48'd100; OPMODE = 8'b11011101;
    clk_n(5);
    check("postsub_p", 64'(P), 64'd50);
    check("postsub_co", 64'(CARRYOUT), 64'd0);

    // Pre-adder bypass
    B = 18'd10; OPMODE = 8'b00000001;
    clk_n(5);
    check("bypass_bcout", 64'(BCOUT), 64'd10);
    check("bypass_p", 64'(P), 64'd50);

    // Accumulate P+P+1: opmode stage then carry-in stage delay the +1 by one clock
    OPMODE = 8'b00101010;
    clk_n(2);
    exp_p = 48'd100;
    check("double_0", 64'(P), 64'(exp_p));
    for (int k = 1; k < 4; k++) begin
      clk_n(1);
      exp_p = 48'(2 * exp_p + 1);
      check($sformatf("double_%0d", k), 64'(P), 64'(exp_p));
    end

    // CEP=0 freezes P while inputs change
    CEP = 1'b0;
    A = 18'd7; B = 18'd9; OPMODE = 8'b00001101; C = 48'd3;
    clk_n(5);
    check("cep_hold", 64'(P), 64'(exp_p));
    check("cep_pcout", 64'(PCOUT), 64'(exp_p));
    CEP = 1'b1;

    // Carry out of the top bit: all-ones + 1 wraps to 0
    A = 18'd1; B = 18'd1; C = 48'hFFFF_FFFF_FFFF; OPMODE = 8'b00001101;
    clk_n(5);
    check("carry_m", 64'(M), 64'd1);
    check("carry_p", 64'(P), 64'd0);
    check("carry_co", 64'(CARRYOUT), 64'd1);
    check("carry_cof", 64'(CARRYOUTF), 64'd1);

    // Asynchronous reset takes effect without a clock edge
    C = 48'd1000;
    clk_n(5);
    check("pre_async_p", 64'(P), 64'd1001);
    RSTP = 1'b0; RSTM = 1'b0;
    #2;
    check("async_p", 64'(P), 64'd0);
    check("async_m", 64'(M), 64'd0);
    RSTP = 1'b1; RSTM = 1'b1;

    // Random steady-state operations (no P feedback in X/Z)
    for (int i = 0; i < 20; i++) begin
      A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
      C = {16'($urandom), 32'($urandom)};
      PCIN = {16'($urandom), 32'($urandom)};
      CARRYIN = 1'($urandom);
      xs = 2'($urandom_range(0, 2)); if (xs == 2'd2) xs = 2'd3;
      zs = 2'($urandom_range(0, 2)); if (zs == 2'd2) zs = 2'd3;
      OPMODE = {4'($urandom), zs, xs};
      model(A, B, D, C, PCIN, OPMODE);
      clk_n(6);
      check($sformatf("rnd%0d_bcout", i), 64'(BCOUT), 64'(r_b1));
      check($sformatf("rnd%0d_m", i), 64'(M), 64'(r_m));
      check($sformatf("rnd%0d_p", i), 64'(P), 64'(r_sum[47:0]));
      check($sformatf("rnd%0d_co", i), 64'(CARRYOUT), 64'(r_sum[48]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
